// File: rtl/reset_sequencer.sv
// Synchronizes async_in_rst, then releases NUM_STAGES active-low domain resets in order,
// spaced GAP_CYCLES apart; a soft request re-runs the sequence. Option: RST_SEQ_REVERSE_ASSERT_EN.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_HOLD   = 8
) (
  input  logic                  clk,
  input  logic                  async_in_rst,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic                  soft_rst_ack
);

  localparam int MAX_CNT = (GAP_CYCLES > SOFT_HOLD) ? GAP_CYCLES : SOFT_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_STAGES + 1);
  localparam int SW      = SYNC_STAGES - 1;

  localparam logic [CW-1:0]         GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]         HOLD_LAST = CW'(SOFT_HOLD - 1);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] LSB       = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SOFT    = 2'd3
  } state_t;

  // The FSM registers form the last synchronizer flop: they only advance once
  // the chain output is high, which puts T0 on edge SYNC_STAGES after deassert.
  logic [SW-1:0] sync_q;
  logic [SW-1:0] sync_d;
  logic          rst_sync;

  assign sync_d   = (sync_q << 1) | SW'(1);
  assign rst_sync = sync_q[SW-1];

  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [NUM_STAGES-1:0]   rst_n_q;
  logic                    seq_done_q;
  logic                    ack_q;

  always_ff @(posedge clk or negedge async_in_rst) begin
    if (!async_in_rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
    end else if (!rst_sync) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_n_q    <= '0;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        HOLD: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            rst_n_q <= rst_n_q | LSB;
            if (NUM_STAGES == 1) begin
              state_q <= RUN;
              idx_q   <= '0;
            end else begin
              state_q <= RELEASE;
              idx_q   <= IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            // Shifting in a one releases exactly the next bit, so order is structural.
            rst_n_q <= (rst_n_q << 1) | LSB;
            if (idx_q == LAST_IDX) begin
              state_q <= RUN;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        RUN: begin
          if (soft_rst_req) begin
            ack_q      <= 1'b1;
            seq_done_q <= 1'b0;
            cnt_q      <= '0;
            state_q    <= SOFT;
`ifdef RST_SEQ_REVERSE_ASSERT_EN
            rst_n_q    <= rst_n_q >> 1;
            idx_q      <= LAST_IDX;
`else
            rst_n_q    <= '0;
            idx_q      <= '0;
`endif
          end else begin
            seq_done_q <= 1'b1;
          end
        end

        SOFT: begin
`ifdef RST_SEQ_REVERSE_ASSERT_EN
          // idx_q counts the bits still released; the hold only starts once bit 0 is low.
          if (idx_q != '0) begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              rst_n_q <= rst_n_q >> 1;
              idx_q   <= idx_q - IW'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else
`endif
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q <= HOLD;
          cnt_q   <= '0;
          idx_q   <= '0;
          rst_n_q <= '0;
        end
      endcase
    end
  end

  assign rst_n_out    = rst_n_q;
  assign seq_done     = seq_done_q;
  assign soft_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a NUM=1/GAP=1/SYNC=3 instance,
// checked against a timing-formula model, a vector table and hand-written corner sequences.
module tb_reset_sequencer;

  localparam int N0 = 3, G0 = 4, S0 = 2, H0 = 8;
  localparam int N1 = 1, G1 = 1, S1 = 3, H1 = 2;

  logic          clk = 1'b0;
  logic          async_rst;
  logic          req;
  logic [N0-1:0] rst0;
  logic          done0, ack0;
  logic [N1-1:0] rst1;
  logic          done1, ack1;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(N0), .GAP_CYCLES(G0), .SYNC_STAGES(S0), .SOFT_HOLD(H0)) dut (
    .clk(clk), .async_in_rst(async_rst), .soft_rst_req(req),
    .rst_n_out(rst0), .seq_done(done0), .soft_rst_ack(ack0)
  );

  reset_sequencer #(.NUM_STAGES(N1), .GAP_CYCLES(G1), .SYNC_STAGES(S1), .SOFT_HOLD(H1)) dut1 (
    .clk(clk), .async_in_rst(async_rst), .soft_rst_req(req),
    .rst_n_out(rst1), .seq_done(done1), .soft_rst_ack(ack1)
  );

  int errors = 0;
  int checks = 0;

  // Model state: edge counter, per-instance T0 edge and last accept edge.
  int ecount = 0;
  bit mrst   = 1'b1;
  int pn[2]  = '{N0, N1};
  int pg[2]  = '{G0, G1};
  int ps[2]  = '{S0, S1};
  int ph[2]  = '{H0, H1};
  int t0[2]  = '{1 << 30, 1 << 30};
  int acc[2] = '{-1, -1};

  function automatic int hold_len(int d);
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    return ph[d] + (pn[d] - 1) * pg[d];
`else
    return ph[d];
`endif
  endfunction

  function automatic int exp_ones(int d);
    int k, v;
    if (mrst) return 0;
    k = ecount - t0[d];
    if (k >= 0) begin
      v = (k + 1) / pg[d];
      return (v > pn[d]) ? pn[d] : v;
    end
`ifdef RST_SEQ_REVERSE_ASSERT_EN
    if (acc[d] >= 0 && ecount >= acc[d]) begin
      v = pn[d] - 1 - (ecount - acc[d]) / pg[d];
      return (v < 0) ? 0 : v;
    end
`endif
    return 0;
  endfunction

  function automatic logic [31:0] exp_mask(int d);
    return (32'd1 << exp_ones(d)) - 32'd1;
  endfunction

  function automatic logic [31:0] exp_done(int d);
    return 32'((!mrst) && (ecount - t0[d] >= pn[d] * pg[d]));
  endfunction

  function automatic logic [31:0] exp_ack(int d);
    return 32'((!mrst) && (acc[d] == ecount));
  endfunction

  task automatic model_edge(int d, logic r);
    if (!mrst && r && (ecount - t0[d] >= pn[d] * pg[d])) begin
      acc[d] = ecount;
      t0[d]  = ecount + hold_len(d) + 1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, ecount, $time);
    end
  endtask

  task automatic check_model();
    chk("m0_rst_n", 32'(rst0),  exp_mask(0));
    chk("m0_done",  32'(done0), exp_done(0));
    chk("m0_ack",   32'(ack0),  exp_ack(0));
    chk("m1_rst_n", 32'(rst1),  exp_mask(1));
    chk("m1_done",  32'(done1), exp_done(1));
    chk("m1_ack",   32'(ack1),  exp_ack(1));
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      ecount++;
      model_edge(0, req);
      model_edge(1, req);
      #1;
      check_model();
    end
  endtask

  // Asserts reset mid-cycle and checks outputs before any further clock edge.
  task automatic rst_assert();
    #1;
    async_rst = 1'b0;
    mrst      = 1'b1;
    acc[0]    = -1;
    acc[1]    = -1;
    #1;
    check_model();
  endtask

  task automatic rst_release();
    async_rst = 1'b1;
    mrst      = 1'b0;
    t0[0]     = ecount + ps[0];
    t0[1]     = ecount + ps[1];
  endtask

  typedef struct {
    int          n;
    logic        req;
    logic [2:0]  rst_n;
    logic        done;
    logic        ack;
  } vec_t;

  vec_t tbl[20];
  bit   found;

  initial begin
    // Power-on sequence, soft reset at RUN entry, re-release, second soft reset with held request.
    tbl[0]  = '{1,  1'b0, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b0, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{3,  1'b0, 3'b001, 1'b0, 1'b0};
    tbl[3]  = '{3,  1'b0, 3'b001, 1'b0, 1'b0};
    tbl[4]  = '{1,  1'b0, 3'b011, 1'b0, 1'b0};
    tbl[5]  = '{3,  1'b0, 3'b011, 1'b0, 1'b0};
    tbl[6]  = '{1,  1'b1, 3'b111, 1'b0, 1'b0};
    tbl[7]  = '{1,  1'b1, 3'b000, 1'b0, 1'b1};
    tbl[8]  = '{1,  1'b0, 3'b000, 1'b0, 1'b0};
    tbl[9]  = '{10, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[10] = '{1,  1'b0, 3'b001, 1'b0, 1'b0};
    tbl[11] = '{4,  1'b0, 3'b011, 1'b0, 1'b0};
    tbl[12] = '{3,  1'b0, 3'b011, 1'b0, 1'b0};
    tbl[13] = '{1,  1'b0, 3'b111, 1'b0, 1'b0};
    tbl[14] = '{1,  1'b0, 3'b111, 1'b1, 1'b0};
    tbl[15] = '{5,  1'b0, 3'b111, 1'b1, 1'b0};
    tbl[16] = '{1,  1'b1, 3'b000, 1'b0, 1'b1};
    tbl[17] = '{1,  1'b1, 3'b000, 1'b0, 1'b0};
    tbl[18] = '{10, 1'b0, 3'b000, 1'b0, 1'b0};
    tbl[19] = '{1,  1'b0, 3'b001, 1'b0, 1'b0};

    async_rst = 1'b0;
    req       = 1'b0;
    #1;
    check_model();
    chk("por_rst_n", 32'(rst0), 32'd0);
    step(5);
    rst_release();

`ifndef RST_SEQ_REVERSE_ASSERT_EN
    for (int i = 0; i < 20; i++) begin
      req = tbl[i].req;
      step(tbl[i].n);
      chk($sformatf("vec%0d_rst_n", i), 32'(rst0),  32'(tbl[i].rst_n));
      chk($sformatf("vec%0d_done", i),  32'(done0), 32'(tbl[i].done));
      chk($sformatf("vec%0d_ack", i),   32'(ack0),  32'(tbl[i].ack));
    end
    req = 1'b0;
`endif

    // Async reset while rst_n_out = 011, then full power-on timing again.
    rst_assert();
    step(3);
    rst_release();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rst0 == 3'b011) begin
        found = 1'b1;
        break;
      end
      step(1);
    end
    chk("reach_011", 32'(found), 32'd1);
    rst_assert();
    chk("async_imm_rst_n", 32'(rst0), 32'd0);
    chk("async_imm_done",  32'(done0), 32'd0);
    step(2);
    rst_release();
    step(5);
    chk("restart_t0p3", 32'(rst0), 32'b001);
    step(4);
    chk("restart_t0p7", 32'(rst0), 32'b011);
    step(4);
    chk("restart_t0p11", 32'(rst0), 32'b111);
    chk("restart_t0p11_done", 32'(done0), 32'd0);
    step(1);
    chk("restart_t0p12_done", 32'(done0), 32'd1);

    // Small instance: T0 is the 3rd edge, release at T0, done at T0+1.
    rst_assert();
    step(2);
    rst_release();
    step(2);
    chk("p1_pre_t0", 32'(rst1), 32'd0);
    step(1);
    chk("p1_t0_rst", 32'(rst1), 32'd1);
    chk("p1_t0_done", 32'(done1), 32'd0);
    step(1);
    chk("p1_t0p1_done", 32'(done1), 32'd1);

`ifdef RST_SEQ_REVERSE_ASSERT_EN
    step(10);
    chk("rev_run", 32'(done0), 32'd1);
    req = 1'b1;
    step(1);
    req = 1'b0;
    chk("rev_e", 32'(rst0), 32'b011);
    chk("rev_e_ack", 32'(ack0), 32'd1);
    step(4);
    chk("rev_e4", 32'(rst0), 32'b001);
    step(4);
    chk("rev_e8", 32'(rst0), 32'b000);
`endif

    // Sub-cycle async pulse still clears everything.
    step(3);
    rst_assert();
    chk("pulse_rst_n", 32'(rst0), 32'd0);
    rst_release();
    step(2);

    // Random soft requests and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 4) begin
        rst_assert();
        rst_release();
      end else if (r < 8) begin
        rst_assert();
        step($urandom_range(1, 4));
        rst_release();
      end
      if ($urandom_range(0, 9) == 0) req = ~req;
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
